// File: rtl/flash_ram_loader.sv
// flash_ram_loader: copies `len` 16-bit words from flash (from src_addr) into
// RAM1 (from dst_addr). The flash is put into read-array mode once per transfer.
// Optional read-back verify of every RAM word: define FLASH_LOAD_VERIFY_EN.
`timescale 1ns/1ps
module flash_ram_loader #(
  parameter int FLASH_AW = 24,
  parameter int RAM_AW   = 18,
  parameter int CNT_W    = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [FLASH_AW-1:0] src_addr,
  input  logic [RAM_AW-1:0]   dst_addr,
  input  logic [CNT_W-1:0]    len,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CNT_W-1:0]    count,
  output logic [7:0]          ledA,
  output logic [7:0]          ledB,
  inout  wire  [15:0]         FlashData,
  output logic [23:0]         FlashAddr,
  output logic                FlashByte,
  output logic                FlashVpen,
  output logic                FlashCE,
  output logic                FlashOE,
  output logic                FlashWE,
  output logic                FlashRP,
  inout  wire  [15:0]         Ram1Data,
  output logic [RAM_AW-1:0]   Ram1Addr,
  output logic                Ram1OE,
  output logic                Ram1WE,
  output logic                Ram1EN,
  output logic                rdn,
  output logic                wrn
);

  localparam int WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_CMD_REL,
    S_RD,
    S_RAM_WR,
    S_RAM_REL,
`ifdef FLASH_LOAD_VERIFY_EN
    S_VFY_RD,
    S_VFY_CMP,
`endif
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [FLASH_AW-1:0] r_src;
  logic [RAM_AW-1:0]   r_dst;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_count;
  logic [15:0]         r_word;
  logic [WAIT_W-1:0]   r_wait;
  logic                w_flash_drv;
  logic                w_ram_drv;
  logic                w_rd_last;
  logic                w_last_word;

  assign w_rd_last   = (r_wait == WAIT_W'(WAIT_CYC - 1));
  assign w_last_word = ((r_count + CNT_W'(1)) == r_len);

  // Tri-state drivers: each bus is driven only in its single write state.
  assign FlashData = w_flash_drv ? 16'h00FF : 16'hzzzz;
  assign Ram1Data  = w_ram_drv ? r_word : 16'hzzzz;

  assign FlashAddr = 24'(r_src);
  assign Ram1Addr  = r_dst;
  assign count     = r_count;
  assign ledA      = r_word[15:8];
  assign ledB      = r_word[7:0];
  assign FlashByte = 1'b1;
  assign FlashVpen = 1'b1;
  assign FlashRP   = 1'b1;
  assign rdn       = 1'b1;
  assign wrn       = 1'b1;

`ifdef FLASH_LOAD_VERIFY_EN
  logic r_err;
  logic w_vfy_match;
  assign w_vfy_match = (Ram1Data == r_word);
  assign err         = r_err;
`else
  assign err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and bus strobes, decoded from the current state.
  always_comb begin
    w_next      = r_state;
    busy        = (r_state != S_IDLE);
    done        = 1'b0;
    FlashCE     = 1'b1;
    FlashOE     = 1'b1;
    FlashWE     = 1'b1;
    Ram1EN      = 1'b1;
    Ram1OE      = 1'b1;
    Ram1WE      = 1'b1;
    w_flash_drv = 1'b0;
    w_ram_drv   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (len == '0) ? S_DONE : S_CMD;
      end
      S_CMD: begin
        FlashCE     = 1'b0;
        FlashWE     = 1'b0;
        w_flash_drv = 1'b1;
        w_next      = S_CMD_REL;
      end
      S_CMD_REL: begin
        FlashCE = 1'b0;
        w_next  = S_RD;
      end
      S_RD: begin
        FlashCE = 1'b0;
        FlashOE = 1'b0;
        if (w_rd_last) w_next = S_RAM_WR;
      end
      S_RAM_WR: begin
        FlashCE   = 1'b0;
        Ram1EN    = 1'b0;
        Ram1WE    = 1'b0;
        w_ram_drv = 1'b1;
        w_next    = S_RAM_REL;
      end
      S_RAM_REL: begin
        FlashCE = 1'b0;
        Ram1EN  = 1'b0;
`ifdef FLASH_LOAD_VERIFY_EN
        w_next  = S_VFY_RD;
`else
        w_next  = w_last_word ? S_DONE : S_RD;
`endif
      end
`ifdef FLASH_LOAD_VERIFY_EN
      S_VFY_RD: begin
        FlashCE = 1'b0;
        Ram1EN  = 1'b0;
        Ram1OE  = 1'b0;
        w_next  = S_VFY_CMP;
      end
      S_VFY_CMP: begin
        FlashCE = 1'b0;
        Ram1EN  = 1'b0;
        Ram1OE  = 1'b0;
        w_next  = (!w_vfy_match || w_last_word) ? S_DONE : S_RD;
      end
`endif
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Transfer datapath: latched addresses/length, wait counter, captured word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_count <= '0;
      r_word  <= '0;
      r_wait  <= '0;
`ifdef FLASH_LOAD_VERIFY_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src   <= src_addr;
            r_dst   <= dst_addr;
            r_len   <= len;
            r_count <= '0;
            r_wait  <= '0;
`ifdef FLASH_LOAD_VERIFY_EN
            r_err   <= 1'b0;
`endif
          end
        end
        S_RD: begin
          if (w_rd_last) begin
            r_word <= FlashData;
            r_wait <= '0;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
`ifdef FLASH_LOAD_VERIFY_EN
        // Advance only once the word has read back correctly, so on a
        // mismatch count still names the failing word.
        S_VFY_CMP: begin
          if (w_vfy_match) begin
            r_count <= r_count + CNT_W'(1);
            r_src   <= r_src + FLASH_AW'(1);
            r_dst   <= r_dst + RAM_AW'(1);
          end else begin
            r_err   <= 1'b1;
          end
        end
`else
        S_RAM_REL: begin
          r_count <= r_count + CNT_W'(1);
          r_src   <= r_src + FLASH_AW'(1);
          r_dst   <= r_dst + RAM_AW'(1);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
